// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD counter family.
// bcd_valid() is the single definition of a legal decimal nibble.
package bcd_pkg;

    localparam int              DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade register. Clear beats load beats inc/dec.
// The top guarantees that inc and dec are never both high.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               at_max,
    output logic               at_min
);

    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == BCD_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= BCD_MIN;
        end else if (clr) begin
            digit <= BCD_MIN;
        end else if (ld) begin
            digit <= ld_val;
        end else if (inc) begin
            digit <= at_max ? BCD_MIN : digit + DIGIT_W'(1);
        end else if (dec) begin
            digit <= at_min ? BCD_MAX : digit - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_counter_4d.sv
// Multi-decade BCD up/down counter with a clock prescaler.
// All decades update on the same edge; carries come from a combinational enable chain.
module bcd_counter_4d
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 5_000_000,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  step,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_TERM = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]                    pre;
    logic [DIGITS-1:0][DIGIT_W-1:0]     digits;
    logic [DIGITS-1:0][DIGIT_W-1:0]     ld_digits;
    logic [DIGITS-1:0]                  at_max, at_min, inc, dec;
    logic [DIGITS:0]                    chain_up, chain_dn;
    logic                               load_ok, tick, step_now, wrap_now;

    assign ld_digits = load_val;
    assign bcd_out   = digits;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(ld_digits[i])) load_ok = 1'b0;
        end
    end

    assign tick     = en && (pre == PS_TERM);
    // Any load request, accepted or not, swallows a coincident step.
    assign step_now = tick && !clear && !load;

    assign chain_up[0] = 1'b1;
    assign chain_dn[0] = 1'b1;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            assign chain_up[g+1] = chain_up[g] & at_max[g];
            assign chain_dn[g+1] = chain_dn[g] & at_min[g];
            assign inc[g]        = step_now &  up_dn & chain_up[g];
            assign dec[g]        = step_now & ~up_dn & chain_dn[g];

            bcd_digit_cell u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .inc    (inc[g]),
                .dec    (dec[g]),
                .clr    (clear),
                .ld     (load && load_ok),
                .ld_val (ld_digits[g]),
                .digit  (digits[g]),
                .at_max (at_max[g]),
                .at_min (at_min[g])
            );
        end
    endgenerate

    assign wrap_now = step_now && (up_dn ? chain_up[DIGITS] : chain_dn[DIGITS]);

    // A rejected load leaves the prescaler phase untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (clear || (load && load_ok)) begin
            pre <= '0;
        end else if (!load && en) begin
            pre <= tick ? '0 : pre + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            step     <= step_now;
            wrap     <= wrap_now;
            load_err <= !clear && load && !load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_counter_4d.sv
// Scoreboard bench: the driver pushes the predicted post-edge outputs from an
// integer-arithmetic model; a monitor pops and compares after every rising edge.
module tb_bcd_counter_4d;

    localparam int PRESCALE = 4;
    localparam int DIGITS   = 4;
    localparam int W        = 4 * DIGITS;
    localparam int MOD      = 10000;

    typedef struct packed {
        logic [W-1:0] bcd;
        logic         step;
        logic         wrap;
        logic         lerr;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, en, up_dn, clear, load;
    logic [W-1:0] load_val;
    logic [W-1:0] bcd_out;
    logic         step, wrap, load_err;

    exp_t exp_q[$];
    int   m_cnt = 0;
    int   m_pre = 0;
    int   checks = 0;
    int   errors = 0;

    bcd_counter_4d #(.PRESCALE(PRESCALE), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .bcd_out  (bcd_out),
        .step     (step),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit decode(input logic [W-1:0] lv, output int v);
        int p;
        bit ok;
        p  = 1;
        v  = 0;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lv[4*i +: 4] > 4'd9) ok = 1'b0;
            v = v + int'(lv[4*i +: 4]) * p;
            p = p * 10;
        end
        return ok;
    endfunction

    // Predict the outputs after the coming rising edge from the current inputs.
    task automatic model_step();
        exp_t x;
        int   v;
        bit   tick;
        x    = '0;
        tick = en && (m_pre == PRESCALE - 1);
        if (clear) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (load) begin
            if (decode(load_val, v)) begin
                m_cnt = v;
                m_pre = 0;
            end else begin
                x.lerr = 1'b1;
            end
        end else if (en) begin
            if (tick) begin
                m_pre  = 0;
                x.step = 1'b1;
                if (up_dn) begin
                    x.wrap = (m_cnt == MOD - 1);
                    m_cnt  = (m_cnt + 1) % MOD;
                end else begin
                    x.wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MOD - 1) % MOD;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
        x.bcd = to_bcd(m_cnt);
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                       input logic [W-1:0] lv);
        @(negedge clk);
        en = e; up_dn = u; clear = c; load = l; load_val = lv;
        model_step();
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_out !== '0 || step !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got bcd=%h step=%b wrap=%b lerr=%b, want 0", bcd_out, step, wrap, load_err);
        end
        m_cnt = 0;
        m_pre = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step();
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < DIGITS; i++) begin
                checks++;
                if (!(bcd_out[4*i +: 4] <= 4'd9)) begin
                    errors++;
                    $display("FAIL digit_range: digit %0d = %h, want <= 9", i, bcd_out[4*i +: 4]);
                end
            end
            if (!rst_n) begin
                checks++;
                if (bcd_out !== '0 || step !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: got bcd=%h step=%b wrap=%b lerr=%b, want 0", bcd_out, step, wrap, load_err);
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL no_expect: output at %0t with no prediction queued", $time);
            end else begin
                x = exp_q.pop_front();
                checks++;
                if (bcd_out !== x.bcd || step !== x.step || wrap !== x.wrap || load_err !== x.lerr) begin
                    errors++;
                    $display("FAIL outputs @%0t: got bcd=%h step=%b wrap=%b lerr=%b, want bcd=%h step=%b wrap=%b lerr=%b",
                             $time, bcd_out, step, wrap, load_err, x.bcd, x.step, x.wrap, x.lerr);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        logic [W-1:0] lv;
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        do_reset();

        // free-running up count through the 9 -> 10 carry
        repeat (40) cyc(1, 1, 0, 0, '0);

        // up wrap from all nines
        cyc(1, 1, 0, 1, 16'h9998);
        repeat (10) cyc(1, 1, 0, 0, '0);

        // down through zero and wrap to all nines
        cyc(1, 0, 0, 1, 16'h0001);
        repeat (10) cyc(1, 0, 0, 0, '0);

        // rejected load keeps count and prescaler phase
        cyc(1, 1, 0, 0, '0);
        cyc(1, 1, 0, 1, 16'h12A4);
        repeat (6) cyc(1, 1, 0, 0, '0);

        // clear + load on the terminal prescaler cycle
        guard = 0;
        while (m_pre != PRESCALE - 1 && guard < 10) begin
            cyc(1, 1, 0, 0, '0);
            guard++;
        end
        cyc(1, 1, 1, 1, 16'h0123);
        repeat (6) cyc(1, 1, 0, 0, '0);

        // freeze with en low, including a load that lands while frozen
        repeat (2) cyc(1, 1, 0, 0, '0);
        repeat (10) cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 1, 16'h0042);
        repeat (3) cyc(0, 0, 0, 0, '0);
        repeat (8) cyc(1, 0, 0, 0, '0);

        // async reset mid-count at 0457
        cyc(1, 1, 0, 1, 16'h0450);
        guard = 0;
        while (m_cnt != 457 && guard < 100) begin
            cyc(1, 1, 0, 0, '0);
            guard++;
        end
        checks++;
        if (m_cnt != 457) begin
            errors++;
            $display("FAIL reach_0457: model count %0d, want 457", m_cnt);
        end
        cyc(1, 1, 0, 0, '0);
        do_reset();
        repeat (12) cyc(1, 1, 0, 0, '0);

        // randomized traffic
        repeat (800) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                lv = '0;
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < DIGITS; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
                end else begin
                    lv = W'($urandom);
                end
                cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 49) == 0,
                    $urandom_range(0, 19) == 0, lv);
            end
        end

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
